snn_output_spike_monitor: RTL and testbench



---
 rtl/snn_spike_pkg.sv | 21 ++
 rtl/snn_spike_fifo.sv | 56 +++++
 rtl/snn_output_spike_monitor.sv | 128 ++++++++++++
 tb/tb_snn_output_spike_monitor.sv | 346 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/snn_spike_pkg.sv
// Output spike word layout shared by the spike generator and the output monitor.
package snn_spike_pkg;

  localparam int WORD_W      = 32;
  localparam int TS_MSB      = 31;
  localparam int TS_LSB      = 18;
  localparam int PAYLOAD_MSB = 17;
  localparam int PAYLOAD_LSB = 10;
  localparam int NID_MSB     = 9;
  localparam int NID_LSB     = 0;
  localparam int NID_W       = NID_MSB - NID_LSB + 1;
  localparam int TS_W        = TS_MSB - TS_LSB + 1;
  localparam int PAYLOAD_W   = PAYLOAD_MSB - PAYLOAD_LSB + 1;

  typedef struct packed {
    logic [TS_W-1:0]      timestamp;
    logic [PAYLOAD_W-1:0] payload;
    logic [NID_W-1:0]     neuron_id;
  } spike_word_t;

endpackage

// File: rtl/snn_spike_fifo.sv
// Synchronous first-word-fall-through FIFO; full/empty come from the registered level.
module snn_spike_fifo
  import snn_spike_pkg::*;
#(
  parameter int  DEPTH = 16,
  parameter int  WIDTH = WORD_W,
  localparam int AW    = $clog2(DEPTH),
  localparam int LW    = AW + 1
) (
  input  logic             clk_100mhz,
  input  logic             sys_rst_n,
  input  logic             clear,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] wdata,
  output logic [WIDTH-1:0] rdata,
  output logic             full,
  output logic             empty,
  output logic [LW-1:0]    level
);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign full    = (level == LW'(DEPTH));
  assign empty   = (level == '0);
  assign do_push = push & ~full & ~clear;
  assign do_pop  = pop & ~empty & ~clear;

  always_ff @(posedge clk_100mhz or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else if (clear) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      level <= level + LW'(do_push) - LW'(do_pop);
    end
  end

  always_ff @(posedge clk_100mhz) begin
    if (do_push) mem[wr_ptr] <= wdata;
  end

  // Storage is never reset, so the head is masked while nothing valid is held.
  assign rdata = empty ? '0 : mem[rd_ptr];

endmodule

// File: rtl/snn_output_spike_monitor.sv
// Sink for the accelerator's output spike stream: FIFO for a pop reader plus
// total/drop/window statistics and a stretched activity LED.
module snn_output_spike_monitor
  import snn_spike_pkg::*;
#(
  parameter int  FIFO_DEPTH     = 16,
  parameter int  WINDOW_CYCLES  = 1000000,
  parameter int  STRETCH_CYCLES = 4000000,
  parameter int  DROP_WHEN_FULL = 1,
  localparam int LVL_W          = $clog2(FIFO_DEPTH) + 1
) (
  input  logic              clk_100mhz,
  input  logic              sys_rst_n,
  input  logic [31:0]       s_axis_tdata,
  input  logic              s_axis_tvalid,
  output logic              s_axis_tready,
  input  logic              s_axis_tlast,
  input  logic              enable,
  input  logic              clear,
  input  logic              pop_ready,
  output logic              pop_valid,
  output logic [31:0]       pop_data,
  output logic [LVL_W-1:0]  fifo_level,
  output logic [31:0]       total_count,
  output logic [31:0]       drop_count,
  output logic [31:0]       window_count,
  output logic              window_done,
  output logic [NID_W-1:0]  last_neuron_id,
  output logic [TS_W-1:0]   last_timestamp,
  output logic              overflow,
  output logic              led_activity
);

  localparam int WIN_W = $clog2(WINDOW_CYCLES);
  localparam int STR_W = $clog2(STRETCH_CYCLES + 1);

  function automatic logic [31:0] sat_inc(input logic [31:0] v, input logic inc);
    return (inc && (v != 32'hFFFF_FFFF)) ? v + 32'd1 : v;
  endfunction

  logic             full;
  logic             empty;
  logic             run;
  logic             accept;
  logic             drop;
  logic             win_wrap;
  logic [WIN_W-1:0] win_cnt;
  logic [31:0]      accum;
  logic [STR_W-1:0] stretch_cnt;
  logic             unused_tlast;

  assign unused_tlast = s_axis_tlast;

  // run holds backpressure-mode tready low while in reset and for the first edge after.
  assign s_axis_tready = (DROP_WHEN_FULL != 0) ? 1'b1 : (run & ~full & ~clear);
  assign accept        = s_axis_tvalid & s_axis_tready & enable & ~clear;
  assign drop          = accept & full;
  assign win_wrap      = (win_cnt == WIN_W'(WINDOW_CYCLES - 1));
  assign window_done   = win_wrap & ~clear;
  assign led_activity  = (stretch_cnt != '0);
  assign pop_valid     = ~empty;

  snn_spike_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (WORD_W)
  ) u_fifo (
    .clk_100mhz (clk_100mhz),
    .sys_rst_n  (sys_rst_n),
    .clear      (clear),
    .push       (accept),
    .pop        (pop_ready),
    .wdata      (s_axis_tdata),
    .rdata      (pop_data),
    .full       (full),
    .empty      (empty),
    .level      (fifo_level)
  );

  always_ff @(posedge clk_100mhz or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      run            <= 1'b0;
      total_count    <= '0;
      drop_count     <= '0;
      overflow       <= 1'b0;
      last_neuron_id <= '0;
      last_timestamp <= '0;
      win_cnt        <= '0;
      accum          <= '0;
      window_count   <= '0;
      stretch_cnt    <= '0;
    end else if (clear) begin
      run            <= 1'b1;
      total_count    <= '0;
      drop_count     <= '0;
      overflow       <= 1'b0;
      last_neuron_id <= '0;
      last_timestamp <= '0;
      win_cnt        <= '0;
      accum          <= '0;
      window_count   <= '0;
      stretch_cnt    <= '0;
    end else begin
      run         <= 1'b1;
      total_count <= sat_inc(total_count, accept);
      drop_count  <= sat_inc(drop_count, drop);
      if (drop) overflow <= 1'b1;
      if (accept) begin
        last_neuron_id <= s_axis_tdata[NID_MSB:NID_LSB];
        last_timestamp <= s_axis_tdata[TS_MSB:TS_LSB];
      end
      // A spike landing on the wrap cycle is credited to the window that is closing.
      if (win_wrap) begin
        win_cnt      <= '0;
        window_count <= sat_inc(accum, accept);
        accum        <= '0;
      end else begin
        win_cnt <= win_cnt + 1'b1;
        accum   <= sat_inc(accum, accept);
      end
      if (accept) begin
        stretch_cnt <= STR_W'(STRETCH_CYCLES);
      end else if (stretch_cnt != '0) begin
        stretch_cnt <= stretch_cnt - 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_snn_output_spike_monitor.sv
// Scoreboard bench: a drop-mode and a backpressure-mode monitor checked against a cycle model.
module tb_snn_output_spike_monitor;
  import snn_spike_pkg::*;

  localparam int D = 16;
  localparam int W = 100;
  localparam int S = 50;

  logic        clk_100mhz = 1'b0;
  logic        sys_rst_n  = 1'b0;
  logic        enable     = 1'b0;
  logic        clear      = 1'b0;
  logic [1:0]  tvalid     = '0;
  logic [1:0]  pop_ready  = '0;
  logic [31:0] tdata [2];

  logic [1:0]  tready, pop_valid, window_done, overflow, led;
  logic [31:0] pop_data [2];
  logic [31:0] total [2];
  logic [31:0] drops [2];
  logic [31:0] wcnt [2];
  logic [4:0]  level [2];
  logic [9:0]  lid [2];
  logic [13:0] lts [2];

  int checks   = 0;
  int failures = 0;
  bit hs_bp    = 1'b0;

  typedef logic [31:0] wq_t[$];
  wq_t         exp_q [2];
  int          m_lvl [2];
  int          m_cyc [2];
  int          m_lastacc [2];
  bit          m_ovf [2];
  bit          m_run [2];
  bit          m_hasacc [2];
  logic [31:0] m_total [2];
  logic [31:0] m_drop [2];
  logic [31:0] m_accum [2];
  logic [31:0] m_wcnt [2];
  logic [9:0]  m_lid [2];
  logic [13:0] m_lts [2];

  always #5 clk_100mhz = ~clk_100mhz;

  snn_output_spike_monitor #(
    .FIFO_DEPTH(D), .WINDOW_CYCLES(W), .STRETCH_CYCLES(S), .DROP_WHEN_FULL(1)
  ) u_drop (
    .clk_100mhz(clk_100mhz), .sys_rst_n(sys_rst_n),
    .s_axis_tdata(tdata[0]), .s_axis_tvalid(tvalid[0]), .s_axis_tready(tready[0]),
    .s_axis_tlast(1'b1), .enable(enable), .clear(clear),
    .pop_ready(pop_ready[0]), .pop_valid(pop_valid[0]), .pop_data(pop_data[0]),
    .fifo_level(level[0]), .total_count(total[0]), .drop_count(drops[0]),
    .window_count(wcnt[0]), .window_done(window_done[0]),
    .last_neuron_id(lid[0]), .last_timestamp(lts[0]),
    .overflow(overflow[0]), .led_activity(led[0])
  );

  snn_output_spike_monitor #(
    .FIFO_DEPTH(D), .WINDOW_CYCLES(W), .STRETCH_CYCLES(S), .DROP_WHEN_FULL(0)
  ) u_bp (
    .clk_100mhz(clk_100mhz), .sys_rst_n(sys_rst_n),
    .s_axis_tdata(tdata[1]), .s_axis_tvalid(tvalid[1]), .s_axis_tready(tready[1]),
    .s_axis_tlast(1'b1), .enable(enable), .clear(clear),
    .pop_ready(pop_ready[1]), .pop_valid(pop_valid[1]), .pop_data(pop_data[1]),
    .fifo_level(level[1]), .total_count(total[1]), .drop_count(drops[1]),
    .window_count(wcnt[1]), .window_done(window_done[1]),
    .last_neuron_id(lid[1]), .last_timestamp(lts[1]),
    .overflow(overflow[1]), .led_activity(led[1])
  );

  task automatic chk(input string name, input int inst, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      if (failures <= 40)
        $display("FAIL %s[%0d] actual=%0h required=%0h t=%0t", name, inst, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] sat1(input logic [31:0] v);
    return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
  endfunction

  function automatic bit exp_rdy(input int i);
    if (i == 0) return 1'b1;
    return m_run[i] && (m_lvl[i] < D) && !clear;
  endfunction

  task automatic model_zero(input int i, input bit run_after);
    exp_q[i].delete();
    m_lvl[i] = 0;     m_cyc[i] = 0;    m_lastacc[i] = 0;
    m_ovf[i] = 0;     m_hasacc[i] = 0; m_run[i] = run_after;
    m_total[i] = '0;  m_drop[i] = '0;  m_accum[i] = '0; m_wcnt[i] = '0;
    m_lid[i] = '0;    m_lts[i] = '0;
  endtask

  task automatic model_step(input int i);
    bit acc, popd;
    acc = tvalid[i] && exp_rdy(i) && enable && !clear;
    if (clear) begin
      model_zero(i, 1'b1);
      return;
    end
    popd = pop_ready[i] && (m_lvl[i] > 0);
    if (acc) begin
      m_total[i]   = sat1(m_total[i]);
      m_lid[i]     = tdata[i][NID_MSB:NID_LSB];
      m_lts[i]     = tdata[i][TS_MSB:TS_LSB];
      m_hasacc[i]  = 1'b1;
      m_lastacc[i] = m_cyc[i];
      if (m_lvl[i] < D) begin
        exp_q[i].push_back(tdata[i]);
        m_lvl[i]++;
      end else begin
        m_drop[i] = sat1(m_drop[i]);
        m_ovf[i]  = 1'b1;
      end
    end
    if (popd) m_lvl[i]--;
    if ((m_cyc[i] % W) == W - 1) begin
      m_wcnt[i]  = acc ? sat1(m_accum[i]) : m_accum[i];
      m_accum[i] = '0;
    end else if (acc) begin
      m_accum[i] = sat1(m_accum[i]);
    end
    m_cyc[i]++;
    m_run[i] = 1'b1;
  endtask

  // Reference model advances on every active edge, or at once on reset.
  initial begin
    for (int i = 0; i < 2; i++) model_zero(i, 1'b0);
    forever begin
      @(posedge clk_100mhz or negedge sys_rst_n);
      for (int i = 0; i < 2; i++) begin
        if (!sys_rst_n) model_zero(i, 1'b0);
        else model_step(i);
      end
    end
  end

  // Monitor: compares outputs mid-cycle and drains the scoreboard on each pop.
  initial begin
    forever begin
      @(negedge clk_100mhz);
      hs_bp = tvalid[1] && tready[1];
      for (int i = 0; i < 2; i++) begin
        int age;
        bit led_exp;
        age     = m_cyc[i] - m_lastacc[i];
        led_exp = m_hasacc[i] && (age >= 1) && (age <= S);
        chk("tready",       i, tready[i],      exp_rdy(i));
        chk("pop_valid",    i, pop_valid[i],   m_lvl[i] > 0);
        chk("fifo_level",   i, level[i],       m_lvl[i]);
        chk("total_count",  i, total[i],       m_total[i]);
        chk("drop_count",   i, drops[i],       m_drop[i]);
        chk("window_count", i, wcnt[i],        m_wcnt[i]);
        chk("window_done",  i, window_done[i], ((m_cyc[i] % W) == W - 1) && !clear);
        chk("overflow",     i, overflow[i],    m_ovf[i]);
        chk("last_nid",     i, lid[i],         m_lid[i]);
        chk("last_ts",      i, lts[i],         m_lts[i]);
        chk("led",          i, led[i],         led_exp);
        if (pop_valid[i]) begin
          if (exp_q[i].size() == 0) begin
            chk("pop_unexpected", i, pop_data[i], 32'hDEAD_BEEF);
          end else begin
            chk("pop_data", i, pop_data[i], exp_q[i][0]);
            if (pop_ready[i] && !clear) void'(exp_q[i].pop_front());
          end
        end
      end
    end
  end

  function automatic logic [31:0] mk(input int nid, input int ts);
    spike_word_t w;
    w.timestamp = TS_W'(ts);
    w.payload   = PAYLOAD_W'($urandom);
    w.neuron_id = NID_W'(nid);
    return w;
  endfunction

  task automatic step();
    @(posedge clk_100mhz);
    #1;
  endtask

  // The backpressure source keeps an unaccepted word stable, as a stream master must.
  task automatic set_in(input bit va, input logic [31:0] wa, input bit vb, input logic [31:0] wb);
    tvalid[0] = va;
    tdata[0]  = wa;
    if (!(tvalid[1] && !hs_bp)) begin
      tvalid[1] = vb;
      tdata[1]  = wb;
    end
  endtask

  task automatic pulse_clear();
    clear = 1'b1;
    set_in(1'b0, '0, 1'b0, '0);
    step();
    clear = 1'b0;
  endtask

  initial begin
    logic [31:0] w;
    tdata[0] = '0;
    tdata[1] = '0;
    repeat (3) step();
    sys_rst_n = 1'b1;
    enable    = 1'b1;
    step();

    // Three ordered words, held, then drained.
    for (int k = 0; k < 3; k++) begin
      w = mk(5 + k, 1 + k);
      set_in(1'b1, w, 1'b1, w);
      step();
    end
    set_in(1'b0, '0, 1'b0, '0);
    step();
    chk("p2_level", 0, level[0], 3);
    chk("p2_total", 0, total[0], 3);
    chk("p2_nid",   0, lid[0],   7);
    chk("p2_ts",    0, lts[0],   3);
    chk("p2_head",  0, pop_data[0][NID_MSB:NID_LSB], 5);
    pop_ready = 2'b11;
    repeat (3) step();
    pop_ready = 2'b00;
    chk("p2_empty", 0, pop_valid[0], 0);
    repeat (2) step();

    // Fill past full: drop mode loses the excess, backpressure mode stalls.
    pulse_clear();
    for (int k = 0; k < 20; k++) begin
      set_in(1'b1, mk(100 + k, k), 1'b1, mk(200 + k, k));
      step();
    end
    set_in(1'b0, '0, 1'b0, '0);
    chk("p4_level", 0, level[0],    16);
    chk("p4_total", 0, total[0],    20);
    chk("p4_drop",  0, drops[0],    4);
    chk("p4_ovf",   0, overflow[0], 1);
    chk("p3_level", 1, level[1],    16);
    chk("p3_rdy",   1, tready[1],   0);
    chk("p3_held",  1, tvalid[1],   1);
    set_in(1'b1, mk(300, 9), 1'b0, '0);
    pop_ready = 2'b11;
    step();
    pop_ready = 2'b00;
    set_in(1'b0, '0, 1'b0, '0);
    chk("p4_popdrop", 0, drops[0], 5);
    chk("p4_poptot",  0, total[0], 21);
    step();
    chk("p3_total", 1, total[1], 17);
    chk("p3_drop",  1, drops[1], 0);
    chk("p3_refill",1, level[1], 16);

    // Rate window: 7 spikes in 10..60 plus one on the wrap cycle.
    pulse_clear();
    pop_ready = 2'b11;
    for (int c = 0; c < 110; c++) begin
      bit sp;
      sp = (c >= 10 && c <= 60 && (c % 8) == 2) || (c == 99);
      w  = mk(c, c);
      set_in(sp, w, sp, w);
      if (c == 99) chk("p5_done", 0, window_done[0], 1);
      if (c == 100) begin
        chk("p5_wcnt",     0, wcnt[0],        8);
        chk("p5_done_end", 0, window_done[0], 0);
      end
      step();
    end
    set_in(1'b0, '0, 1'b0, '0);

    // LED stretch with a retrigger, then a clear that also swallows a word.
    pulse_clear();
    for (int c = 0; c < 100; c++) begin
      bit sp;
      sp = (c == 5) || (c == 35);
      w  = mk(c, c);
      set_in(sp, w, sp, w);
      if (c == 85) chk("p6_led_on",  0, led[0], 1);
      if (c == 86) chk("p6_led_off", 0, led[0], 0);
      step();
    end
    pulse_clear();
    for (int c = 0; c < 46; c++) begin
      bit sp;
      sp = (c == 5) || (c == 45);
      w  = mk(c, c);
      set_in(sp, w, sp, w);
      if (c == 45) clear = 1'b1;
      step();
    end
    clear = 1'b0;
    set_in(1'b0, '0, 1'b0, '0);
    chk("p6_clr_led",   0, led[0],   0);
    chk("p6_clr_total", 0, total[0], 0);
    chk("p6_clr_level", 0, level[0], 0);
    pop_ready = 2'b00;

    // Reset in the middle of a stream with five words buffered.
    pulse_clear();
    for (int k = 0; k < 5; k++) begin
      set_in(1'b1, mk(k, k), 1'b1, mk(k, k));
      step();
    end
    chk("p1_pre_level", 0, level[0], 5);
    sys_rst_n = 1'b0;
    #1;
    chk("p1_rst_level", 0, level[0],     0);
    chk("p1_rst_pv",    0, pop_valid[0], 0);
    chk("p1_rst_total", 0, total[0],     0);
    chk("p1_rst_rdy",   1, tready[1],    0);
    set_in(1'b0, '0, 1'b0, '0);
    repeat (2) step();
    sys_rst_n = 1'b1;
    chk("p1_rel_pv",  0, pop_valid[0], 0);
    chk("p1_rel_rdy", 0, tready[0],    1);
    step();
    chk("p1_bp_rdy",  1, tready[1],    1);

    // Randomised traffic with occasional clears and resets.
    for (int c = 0; c < 3000; c++) begin
      set_in(($urandom % 4) != 0, $urandom, ($urandom % 4) != 0, $urandom);
      pop_ready = 2'($urandom);
      enable    = ($urandom % 16) != 0;
      clear     = ($urandom % 250) == 0;
      if (($urandom % 700) == 0) sys_rst_n = 1'b0;
      else sys_rst_n = 1'b1;
      step();
    end
    sys_rst_n = 1'b1;
    clear     = 1'b0;
    set_in(1'b0, '0, 1'b0, '0);
    repeat (5) step();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
